// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter owning the select/enable of a shared 3-to-8 decoder.
// Optional forced release after MAX_HOLD grant cycles: define DEC_ARB_TIMEOUT_EN.
module dec_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("dec_rr_arbiter: MAX_HOLD must be within 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] sel_nx;
    logic [2:0] win;
    logic       found;

    // First requester after ptr, wrapping modulo 8; ptr itself is checked last.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] idx;
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef DEC_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_nx;
    logic       timeout_q, timeout_nx;

    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        ptr_nx     = ptr;
        hold_nx    = hold_cnt;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    sel_nx   = win;
                    ptr_nx   = win;
                    hold_nx  = 8'd0;
                end
            end
            GRANT: begin
                hold_nx = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                if (!req[sel]) begin
                    state_nx = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_nx;
            timeout_q <= timeout_nx;
        end
    end

    assign timeout = timeout_q;
`else
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    sel_nx   = win;
                    ptr_nx   = win;
                end
            end
            GRANT: begin
                if (!req[sel]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 3'd0;
            ptr   <= 3'd7;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
        end
    end

    assign en   = (state == GRANT);
    assign busy = en;
    assign gnt  = en ? (8'b1 << sel) : 8'b0;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter: cycle-by-cycle vector table plus a
// hand-written hold/timeout sequence (behaviour follows DEC_ARB_TIMEOUT_EN).
module tb_dec_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    dec_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .en(en),
        .gnt(gnt), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       en;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       timeout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic e,
                       input logic [2:0] s, input logic [7:0] g);
        vec_t v;
        v.rst = r; v.req = rq; v.en = e; v.sel = s; v.gnt = g; v.timeout = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, then sample all outputs 1 time unit after the edge.
    task automatic step(input string name, input logic r, input logic [7:0] rq,
                        input logic e, input logic [2:0] s, input logic [7:0] g,
                        input logic to);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
        check({name, ".en"},      {7'd0, en},      {7'd0, e});
        check({name, ".busy"},    {7'd0, busy},    {7'd0, e});
        check({name, ".gnt"},     gnt,             g);
        check({name, ".timeout"}, {7'd0, timeout}, {7'd0, to});
        if (e) check({name, ".sel"}, {5'd0, sel}, {5'd0, s});
        else if (r) check({name, ".sel_rst"}, {5'd0, sel}, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;

        // reset with all lines requesting, then first grant to 0
        add(1, 8'hFF, 0, 0, 8'h00);
        add(1, 8'hFF, 0, 0, 8'h00);
        add(0, 8'hFF, 1, 0, 8'h01);
        add(0, 8'h00, 0, 0, 8'h00);
        // single requester 5 for three cycles
        add(0, 8'h20, 1, 5, 8'h20);
        add(0, 8'h20, 1, 5, 8'h20);
        add(0, 8'h20, 1, 5, 8'h20);
        add(0, 8'h00, 0, 5, 8'h00);
        // rotation from reset: 0..7 then 0, bubble between each
        add(1, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            logic [7:0] b;
            b = 8'h01 << (i % 8);
            add(0, 8'hFF,      1, 3'(i % 8), b);
            add(0, 8'hFF & ~b, 0, 3'(i % 8), 8'h00);
        end
        // serve 6, then wrap to 0, skip to 3; late 7 waits
        add(0, 8'h40, 1, 6, 8'h40);
        add(0, 8'h00, 0, 6, 8'h00);
        add(0, 8'h09, 1, 0, 8'h01);
        add(0, 8'h89, 1, 0, 8'h01);
        add(0, 8'h88, 0, 0, 8'h00);
        add(0, 8'h88, 1, 3, 8'h08);
        add(0, 8'h80, 0, 3, 8'h00);
        add(0, 8'h80, 1, 7, 8'h80);
        add(0, 8'h00, 0, 7, 8'h00);
        // reset mid-grant of 4 restores ptr=7, so 0 wins over 4
        add(0, 8'h10, 1, 4, 8'h10);
        add(1, 8'h11, 0, 0, 8'h00);
        add(0, 8'h11, 1, 0, 8'h01);
        add(0, 8'h10, 0, 0, 8'h00);
        add(0, 8'h10, 1, 4, 8'h10);
        // release of 4 with simultaneous new request 5: bubble first
        add(0, 8'h20, 0, 4, 8'h00);
        add(0, 8'h20, 1, 5, 8'h20);
        add(0, 8'h00, 0, 5, 8'h00);

        #2;
        for (int k = 0; k < vecs.size(); k++) begin
            step($sformatf("vec%0d", k), vecs[k].rst, vecs[k].req, vecs[k].en,
                 vecs[k].sel, vecs[k].gnt, vecs[k].timeout);
        end

        // long hold with req=8'h06 from reset
        step("hold_rst", 1, 8'h06, 0, 0, 8'h00, 0);
`ifdef DEC_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) step($sformatf("to_g1_%0d", c), 0, 8'h06, 1, 1, 8'h02, 0);
        step("to_pulse1", 0, 8'h06, 0, 1, 8'h00, 1);
        for (int c = 0; c < 4; c++) step($sformatf("to_g2_%0d", c), 0, 8'h06, 1, 2, 8'h04, 0);
        step("to_pulse2", 0, 8'h06, 0, 2, 8'h00, 1);
        step("to_regrant1", 0, 8'h06, 1, 1, 8'h02, 0);
        step("to_drop", 0, 8'h00, 0, 1, 8'h00, 0);
        // lone requester held past the limit is re-granted after its bubble
        step("to_solo_g", 0, 8'h80, 1, 7, 8'h80, 0);
        for (int c = 1; c < 4; c++) step($sformatf("to_solo_%0d", c), 0, 8'h80, 1, 7, 8'h80, 0);
        step("to_solo_pulse", 0, 8'h80, 0, 7, 8'h00, 1);
        step("to_solo_regrant", 0, 8'h80, 1, 7, 8'h80, 0);
`else
        for (int c = 0; c < 12; c++) step($sformatf("hold_g1_%0d", c), 0, 8'h06, 1, 1, 8'h02, 0);
        step("hold_drop", 0, 8'h04, 0, 1, 8'h00, 0);
        step("hold_next2", 0, 8'h04, 1, 2, 8'h04, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
